// File: rtl/ram_pkg.sv
// Shared state type, default geometry and address-width helper for the
// parameterised RAM with power-on/clear sweep.
package ram_pkg;

    typedef enum logic {
        CLR = 1'b0,
        RUN = 1'b1
    } state_e;

    localparam int RAM_WIDTH_DEFAULT = 16;
    localparam int RAM_DEPTH_DEFAULT = 512;

    // Address width never collapses to zero, even for a one-word array.
    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/ram_array.sv
// Word storage: one write port and one synchronous read port whose output
// register holds its value between reads and yields 0 for out-of-range reads.
module ram_array
    import ram_pkg::*;
#(
    parameter  int WIDTH  = RAM_WIDTH_DEFAULT,
    parameter  int DEPTH  = RAM_DEPTH_DEFAULT,
    localparam int ADDR_W = addr_width(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [WIDTH-1:0]  wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [WIDTH-1:0]  rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;
    logic             waddr_ok;
    logic             raddr_ok;

    assign waddr_ok = 32'(waddr_i) < 32'(DEPTH);
    assign raddr_ok = 32'(raddr_i) < 32'(DEPTH);

    // Contents are never reset; writes are simply held off while in reset.
    always_ff @(posedge clk_i) begin
        if (rst_ni && we_i && waddr_ok) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= raddr_ok ? mem_q[raddr_i] : '0;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/ram_param.sv
// Parameterised single-port RAM front end: sweeps the array to zero after
// reset or a clear request, then serves one read or write per cycle.
module ram_param
    import ram_pkg::*;
#(
    parameter  int WIDTH  = RAM_WIDTH_DEFAULT,
    parameter  int DEPTH  = RAM_DEPTH_DEFAULT,
    localparam int ADDR_W = addr_width(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [WIDTH-1:0]  req_wdata,
    output logic              rsp_valid,
    output logic [WIDTH-1:0]  rsp_rdata,
    output logic              rsp_err,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_err_q, rsp_err_d;
    logic              addr_ok;
    logic              arr_we;
    logic              arr_re;
    logic [ADDR_W-1:0] arr_waddr;
    logic [WIDTH-1:0]  arr_wdata;

    assign addr_ok = 32'(req_addr) < 32'(DEPTH);

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        arr_we      = 1'b0;
        arr_waddr   = ptr_q;
        arr_wdata   = '0;
        arr_re      = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        req_ready   = 1'b0;
        busy        = 1'b0;
        unique case (state_q)
            CLR: begin
                busy   = 1'b1;
                arr_we = 1'b1;
                if (clr) begin
                    ptr_d = '0;
                end else if (ptr_q == LAST_ADDR) begin
                    state_d = RUN;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + ADDR_W'(1);
                end
            end
            RUN: begin
                req_ready = 1'b1;
                // A clear wins over any request offered in the same cycle.
                if (clr) begin
                    state_d = CLR;
                    ptr_d   = '0;
                end else if (req_valid) begin
                    if (req_we) begin
                        arr_we    = addr_ok;
                        arr_waddr = req_addr;
                        arr_wdata = req_wdata;
                    end else begin
                        arr_re      = 1'b1;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = !addr_ok;
                    end
                end
            end
            default: state_d = CLR;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= CLR;
            ptr_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    ram_array #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_array (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .we_i    (arr_we),
        .waddr_i (arr_waddr),
        .wdata_i (arr_wdata),
        .re_i    (arr_re),
        .raddr_i (req_addr),
        .rdata_o (rsp_rdata)
    );

    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_ram_param.sv
// Bench for ram_param (WIDTH=16, DEPTH=6): directed scenarios plus random
// traffic, each cycle compared against a word-array reference model.
module tb_ram_param;

    localparam int WIDTH  = 16;
    localparam int DEPTH  = 6;
    localparam int ADDR_W = 3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              clr = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_we = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [WIDTH-1:0]  req_wdata = '0;
    logic              rsp_valid;
    logic [WIDTH-1:0]  rsp_rdata;
    logic              rsp_err;
    logic              busy;

    ram_param #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: array contents, cycles of sweep still to run, and the
    // response expected to be visible in the current cycle.
    int unsigned m_mem [DEPTH];
    int          m_busy_left;
    logic        m_rv;
    logic        m_err;
    logic [15:0] m_data;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 0;
        m_busy_left = DEPTH;
        m_rv        = 1'b0;
        m_err       = 1'b0;
        m_data      = '0;
    endtask

    // Called at a falling edge: check what is visible now, drive the next
    // request, advance the model across the coming rising edge, then wait.
    task automatic cycle(input logic c, input logic v, input logic w,
                         input logic [ADDR_W-1:0] a, input logic [15:0] d);
        logic nrv;
        logic nerr;
        check_eq("busy",      32'(busy),      32'(m_busy_left != 0));
        check_eq("req_ready", 32'(req_ready), 32'(m_busy_left == 0));
        check_eq("rsp_valid", 32'(rsp_valid), 32'(m_rv));
        check_eq("rsp_err",   32'(rsp_err),   32'(m_err));
        check_eq("rsp_rdata", 32'(rsp_rdata), 32'(m_data));
        clr       = c;
        req_valid = v;
        req_we    = w;
        req_addr  = a;
        req_wdata = d;
        if (rst_n) begin
            nrv  = 1'b0;
            nerr = 1'b0;
            if (m_busy_left != 0) begin
                m_busy_left = c ? DEPTH : m_busy_left - 1;
            end else if (c) begin
                for (int i = 0; i < DEPTH; i++) m_mem[i] = 0;
                m_busy_left = DEPTH;
            end else if (v) begin
                if (w) begin
                    if (int'(a) < DEPTH) m_mem[a] = int'(d);
                end else begin
                    nrv    = 1'b1;
                    nerr   = int'(a) >= DEPTH;
                    m_data = nerr ? 16'h0 : 16'(m_mem[a]);
                end
            end
            m_rv  = nrv;
            m_err = nerr;
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic wr(input logic [ADDR_W-1:0] a, input logic [15:0] d);
        cycle(1'b0, 1'b1, 1'b1, a, d);
    endtask

    task automatic rd(input logic [ADDR_W-1:0] a);
        cycle(1'b0, 1'b1, 1'b0, a, 16'($urandom));
    endtask

    // Assert reset at a falling edge with random request traffic, then release.
    task automatic do_reset(input int n);
        rst_n = 1'b0;
        #1;
        model_reset();
        for (int i = 0; i < n; i++)
            cycle(1'($urandom), 1'($urandom), 1'($urandom), 3'($urandom), 16'($urandom));
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        do_reset(2);

        // Power-on sweep, then back-to-back reads of every word.
        idle(DEPTH);
        for (int i = 0; i < DEPTH; i++) rd(3'(i));
        idle(2);

        // Write then immediate read-back.
        wr(3'd3, 16'hBEEF);
        rd(3'd3);
        idle(1);

        // Out-of-range write and read.
        wr(3'd7, 16'h1234);
        rd(3'd7);
        rd(3'd6);
        for (int i = 0; i < DEPTH; i++) rd(3'(i));

        // Fill, clear, verify zeroed.
        for (int i = 0; i < DEPTH; i++) wr(3'(i), 16'hA5A5);
        cycle(1'b1, 1'b0, 1'b0, '0, '0);
        idle(DEPTH);
        for (int i = 0; i < DEPTH; i++) rd(3'(i));

        // Read on the edge before a clear keeps its pre-clear data; the
        // request presented with clr is dropped.
        wr(3'd1, 16'h5A5A);
        rd(3'd1);
        cycle(1'b1, 1'b1, 1'b0, 3'd1, '0);
        idle(2);
        cycle(1'b1, 1'b0, 1'b0, '0, '0);
        idle(DEPTH + 1);
        rd(3'd1);

        // Reset part-way through a sweep, and with a response on the wire.
        cycle(1'b1, 1'b0, 1'b0, '0, '0);
        idle(2);
        do_reset(2);
        idle(DEPTH + 1);
        wr(3'd2, 16'hC0DE);
        rd(3'd2);
        do_reset(1);
        idle(DEPTH);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 149) == 0) begin
                do_reset(int'($urandom_range(1, 3)));
            end else begin
                cycle($urandom_range(0, 39) == 0,
                      $urandom_range(0, 3) != 0,
                      1'($urandom),
                      3'($urandom_range(0, 7)),
                      16'($urandom));
            end
        end
        idle(2);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
